// File: rtl/mem_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch and data access.
// Data is served before instruction, and Stall holds the pipeline until both are done.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          IReq,
  input  logic [AW-1:0] IAddr,
  output logic [DW-1:0] IRdata,
  input  logic          DRead,
  input  logic          DWrite,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWdata,
  output logic [DW-1:0] DRdata,
  output logic          Stall,
  output logic          MemReq,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWdata,
  input  logic [DW-1:0] MemRdata,
  input  logic          MemAck,
  output logic [CW-1:0] StallCount
);

  typedef enum logic [1:0] {IDLE, DATA, INST, RELEASE} stateT;

  stateT state;
  logic  dDone;
  logic  iDone;
  logic  dReqV;

  assign dReqV = DRead | DWrite;
  assign Stall = (state != RELEASE) && ((dReqV && !dDone) || (IReq && !iDone));

  // Memory-side outputs are registered from the next state, so they are valid for the whole
  // cycle the FSM spends in DATA or INST and are zero everywhere else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dDone      <= 1'b0;
      iDone      <= 1'b0;
      IRdata     <= '0;
      DRdata     <= '0;
      StallCount <= '0;
      MemReq     <= 1'b0;
      MemWe      <= 1'b0;
      MemAddr    <= '0;
      MemWdata   <= '0;
    end else begin
      if (Stall && (StallCount != {CW{1'b1}})) begin
        StallCount <= StallCount + CW'(1);
      end
      case (state)
        IDLE: begin
          if (dReqV && !dDone) begin
            state    <= DATA;
            MemReq   <= 1'b1;
            MemWe    <= DWrite;
            MemAddr  <= DAddr;
            MemWdata <= DWdata;
          end else if (IReq && !iDone) begin
            state    <= INST;
            MemReq   <= 1'b1;
            MemWe    <= 1'b0;
            MemAddr  <= IAddr;
            MemWdata <= '0;
          end
        end
        DATA: begin
          if (MemAck) begin
            // A simultaneous read+write request behaves as a store and leaves DRdata alone.
            if (DRead && !DWrite) begin
              DRdata <= MemRdata;
            end
            dDone <= 1'b1;
            if (IReq && !iDone) begin
              state    <= INST;
              MemReq   <= 1'b1;
              MemWe    <= 1'b0;
              MemAddr  <= IAddr;
              MemWdata <= '0;
            end else begin
              state    <= RELEASE;
              MemReq   <= 1'b0;
              MemWe    <= 1'b0;
              MemAddr  <= '0;
              MemWdata <= '0;
            end
          end
        end
        INST: begin
          if (MemAck) begin
            IRdata   <= MemRdata;
            iDone    <= 1'b1;
            state    <= RELEASE;
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemWdata <= '0;
          end
        end
        RELEASE: begin
          dDone <= 1'b0;
          iDone <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, reset corner cases, and
// randomized pipeline cycles checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int SC_MAX = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          IReq = 1'b0;
  logic [AW-1:0] IAddr = '0;
  logic [DW-1:0] IRdata;
  logic          DRead = 1'b0;
  logic          DWrite = 1'b0;
  logic [AW-1:0] DAddr = '0;
  logic [DW-1:0] DWdata = '0;
  logic [DW-1:0] DRdata;
  logic          Stall;
  logic          MemReq;
  logic          MemWe;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWdata;
  logic [DW-1:0] MemRdata = '0;
  logic          MemAck;
  logic [CW-1:0] StallCount;

  mem_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata),
    .DRead(DRead), .DWrite(DWrite), .DAddr(DAddr), .DWdata(DWdata), .DRdata(DRdata),
    .Stall(Stall),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemRdata(MemRdata), .MemAck(MemAck),
    .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iReq;
    logic        dRead;
    logic        dWrite;
    logic [31:0] iAddr;
    logic [31:0] dAddr;
    logic [31:0] wdata;
    int          lat;
    int          expStalls;
    logic [31:0] expIR;
    logic [31:0] expDR;
    int          expSC;
  } vecT;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txnT;

  txnT         txnQ[$];
  logic [31:0] memArr [0:255];
  logic [31:0] refMem [0:255];
  int          latency = 1;
  int          waitCnt = 0;
  int          weCycles = 0;
  logic        ackOverride = 1'b0;
  logic        ackVal = 1'b0;
  logic        modelAck = 1'b0;
  logic        monitorOn = 1'b0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] modelIR;
  logic [31:0] modelDR;
  int          modelSC;
  vecT         vecs [8];

  assign MemAck = ackOverride ? ackVal : modelAck;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Memory environment: acks after `latency` request cycles, read data valid in the ack cycle.
  always @(negedge clk) begin
    modelAck = MemReq && (waitCnt == latency - 1);
    MemRdata = memArr[MemAddr[9:2]];
  end

  always @(posedge clk) begin
    if (monitorOn && !MemReq) begin
      checkOutput("idleBus", MemAddr | MemWdata | {31'b0, MemWe}, 32'h0);
    end
    if (!rst && MemReq && MemAck) begin
      txnQ.push_back('{MemWe, MemAddr, MemWdata});
      if (MemWe) memArr[MemAddr[9:2]] = MemWdata;
    end
    if (!rst && MemReq && MemWe) weCycles++;
    if (rst || !MemReq || MemAck) waitCnt = 0;
    else waitCnt++;
  end

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1; IReq = 1'b0; DRead = 1'b0; DWrite = 1'b0;
    IAddr = '0; DAddr = '0; DWdata = '0;
    @(negedge clk);
    rst = 1'b0;
    modelIR = '0; modelDR = '0; modelSC = 0;
  endtask

  // Transaction-level model: one pipeline cycle costs one arbitration cycle plus the
  // memory latency of each access; the store lands before the fetch reads.
  task automatic modelOp(input vecT v, output vecT r);
    bit dReq;
    r = v;
    dReq = v.dRead || v.dWrite;
    r.expStalls = (dReq || v.iReq) ? 1 + (dReq ? v.lat : 0) + (v.iReq ? v.lat : 0) : 0;
    if (v.dWrite) refMem[v.dAddr[9:2]] = v.wdata;
    else if (v.dRead) modelDR = refMem[v.dAddr[9:2]];
    if (v.iReq) modelIR = refMem[v.iAddr[9:2]];
    modelSC = (modelSC + r.expStalls > SC_MAX) ? SC_MAX : modelSC + r.expStalls;
    r.expIR = modelIR;
    r.expDR = modelDR;
    r.expSC = modelSC;
  endtask

  task automatic applyStimulus(input vecT v, output int stalls);
    txnQ.delete();
    weCycles = 0;
    @(negedge clk);
    latency = v.lat;
    IReq = v.iReq; DRead = v.dRead; DWrite = v.dWrite;
    IAddr = v.iAddr; DAddr = v.dAddr; DWdata = v.wdata;
    #1;
    stalls = 0;
    while (Stall && stalls < 200) begin
      stalls++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOp(input vecT v, input int stalls);
    txnT expQ[$];
    int  n;
    checkOutput("stalls", 32'(stalls), 32'(v.expStalls));
    checkOutput("IRdata", IRdata, v.expIR);
    checkOutput("DRdata", DRdata, v.expDR);
    checkOutput("StallCount", 32'(StallCount), 32'(v.expSC));
    if (v.dRead || v.dWrite) expQ.push_back('{v.dWrite, v.dAddr, v.wdata});
    if (v.iReq) expQ.push_back('{1'b0, v.iAddr, 32'h0});
    checkOutput("txnCount", 32'(txnQ.size()), 32'(expQ.size()));
    n = (txnQ.size() < expQ.size()) ? txnQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput("txnWe", 32'(txnQ[i].we), 32'(expQ[i].we));
      checkOutput("txnAddr", txnQ[i].addr, expQ[i].addr);
      checkOutput("txnWdata", txnQ[i].wdata, expQ[i].wdata);
    end
    checkOutput("weCycles", 32'(weCycles), 32'(v.dWrite ? v.lat : 0));
  endtask

  task automatic runVec(input vecT v);
    int stalls;
    applyStimulus(v, stalls);
    checkOp(v, stalls);
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecT  v;
    vecT  r;
    logic [3:0] ia;
    logic [3:0] da;

    for (int k = 0; k < 256; k++) begin
      memArr[k] = 32'hA000_0000 | 32'(k);
    end
    memArr[1]  = 32'h2008_0005;
    memArr[16] = 32'hDEAD_BEEF;
    for (int k = 0; k < 256; k++) refMem[k] = memArr[k];

    // Reset held with a fetch pending, then ack tied high.
    IReq = 1'b1; IAddr = 32'h04; ackOverride = 1'b1; ackVal = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstIRdata", IRdata, 32'h0);
    checkOutput("rstDRdata", DRdata, 32'h0);
    checkOutput("rstStall", 32'(Stall), 32'h1);
    checkOutput("rstMemReq", 32'(MemReq), 32'h0);
    checkOutput("rstStallCount", 32'(StallCount), 32'h0);
    monitorOn = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checkOutput($sformatf("stallPattern%0d", i), 32'(Stall), 32'((i % 3) != 2));
      if (i % 3 == 2) checkOutput("IRdataRelease", IRdata, 32'h2008_0005);
      @(negedge clk);
    end
    ackOverride = 1'b0;
    applyReset();

    // iReq dRead dWrite iAddr dAddr wdata lat | stalls IR DR SC
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h04, 32'h00, 32'h0, 1, 2, 32'h2008_0005, 32'h0, 2};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h08, 32'h40, 32'h0, 1, 3, 32'hA000_0002, 32'hDEAD_BEEF, 5};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0C, 32'h44, 32'h1234_5678, 3, 7, 32'hA000_0003, 32'hDEAD_BEEF, 12};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h00, 32'h44, 32'h0, 2, 3, 32'hA000_0003, 32'h1234_5678, 15};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h00, 32'h0, 1, 0, 32'hA000_0003, 32'h1234_5678, 15};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h00, 32'h0, 1, 2, 32'hA000_0004, 32'h1234_5678, 15};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h00, 32'h48, 32'hCAFE_F00D, 1, 2, 32'hA000_0004, 32'h1234_5678, 15};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 32'h00, 32'h48, 32'h0, 1, 2, 32'hA000_0004, 32'hCAFE_F00D, 15};
    foreach (vecs[i]) begin
      modelOp(vecs[i], r);
      runVec(vecs[i]);
    end

    // Reset while a load waits for its ack; a late ack must not touch any register.
    ackOverride = 1'b1; ackVal = 1'b0;
    @(negedge clk);
    DRead = 1'b1; DWrite = 1'b0; IReq = 1'b0; DAddr = 32'h40;
    @(posedge clk);
    #1;
    checkOutput("midMemReq", 32'(MemReq), 32'h1);
    checkOutput("midMemAddr", MemAddr, 32'h40);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abortMemReq", 32'(MemReq), 32'h0);
    checkOutput("abortMemAddr", MemAddr, 32'h0);
    checkOutput("abortDRdata", DRdata, 32'h0);
    checkOutput("abortIRdata", IRdata, 32'h0);
    @(negedge clk);
    rst = 1'b0; DRead = 1'b0; ackVal = 1'b1;
    @(negedge clk);
    ackVal = 1'b0;
    #1;
    checkOutput("lateAckDRdata", DRdata, 32'h0);
    checkOutput("lateAckIRdata", IRdata, 32'h0);
    checkOutput("lateAckMemReq", 32'(MemReq), 32'h0);
    checkOutput("lateAckStallCount", 32'(StallCount), 32'h0);
    ackOverride = 1'b0;

    for (int n = 0; n < 48; n++) begin
      if (n % 4 == 0) applyReset();
      ia = 4'($urandom_range(0, 15));
      da = 4'($urandom_range(0, 15));
      v.iReq   = 1'($urandom_range(0, 1));
      v.dRead  = 1'($urandom_range(0, 1));
      v.dWrite = 1'($urandom_range(0, 1));
      v.iAddr  = {26'b0, ia, 2'b00};
      v.dAddr  = {26'b0, da, 2'b00};
      v.wdata  = $urandom;
      v.lat    = $urandom_range(1, 3);
      modelOp(v, r);
      runVec(r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
